// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display blocks.
package display_pkg;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned NIB_W   = 4;
    localparam logic [NDIGITS-1:0] DIG_OFF = 4'b1111;

    typedef logic [1:0]  digit_idx_t;
    typedef logic [15:0] bcd4_t;

    // Nibble of digit i (digit 0 is the least significant).
    function automatic logic [NIB_W-1:0] nibble_at(input bcd4_t v, input digit_idx_t i);
        logic [NIB_W-1:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    // True when digit i and every more significant digit are zero; digit 0 never qualifies.
    function automatic logic lead_zero(input bcd4_t v, input digit_idx_t i);
        logic z;
        case (i)
            2'd0:    z = 1'b0;
            2'd1:    z = (v[15:4] == 12'h000);
            2'd2:    z = (v[15:8] == 8'h00);
            default: z = (v[15:12] == 4'h0);
        endcase
        return z;
    endfunction

    // Active-low one-hot digit select.
    function automatic logic [NDIGITS-1:0] digit_sel(input digit_idx_t i);
        return ~(NDIGITS'(1) << i);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV prescaler; tick is high for the last cycle of each period.
module scan_prescaler #(
    parameter int unsigned DIV = 50000
) (
    input  logic CLK,
    input  logic nRST,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] count;

    // tick is registered alongside count so that tick == (count == DIV-1) every cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (tick) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= (count == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit time-multiplexed scanner feeding a seven-segment decoder, with
// frame-aligned value loading, leading-zero blanking and global blank.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [15:0]         D,
    input  logic                LD,
    input  logic                LZB,
    input  logic                BLK,
    output logic                A3,
    output logic                A2,
    output logic                A1,
    output logic                A0,
    output logic                EN,
    output logic [NDIGITS-1:0]  DIG,
    output logic                PEND
);

    logic             tick;
    logic             frame_end;
    digit_idx_t       idx;
    bcd4_t            disp;
    bcd4_t            pend_val;
    logic [NIB_W-1:0] nib;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK  (CLK),
        .nRST (nRST),
        .tick (tick)
    );

    // The tick that finishes the last digit slot closes the frame.
    assign frame_end = tick && (idx == digit_idx_t'(NDIGITS - 1));

    assign {A3, A2, A1, A0} = nib;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            idx      <= '0;
            disp     <= '0;
            pend_val <= '0;
            PEND     <= 1'b0;
            DIG      <= DIG_OFF;
            EN       <= 1'b0;
            nib      <= '0;
        end else begin
            if (tick) begin
                idx <= idx + 2'd1;
            end

            // A load landing on the frame-closing tick bypasses the pending register.
            if (LD) begin
                if (frame_end) begin
                    disp <= D;
                    PEND <= 1'b0;
                end else begin
                    pend_val <= D;
                    PEND     <= 1'b1;
                end
            end else if (frame_end && PEND) begin
                disp <= pend_val;
                PEND <= 1'b0;
            end

            // Slot outputs use the display value in force during the slot's own frame.
            if (BLK) begin
                DIG <= DIG_OFF;
                EN  <= 1'b0;
            end else if (tick) begin
                DIG <= digit_sel(idx);
                nib <= nibble_at(disp, idx);
                EN  <= !(LZB && lead_zero(disp, idx));
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized + directed bench for display_scan_ctrl against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [15:0] d;
    logic        ld, lzb, blk;
    logic        a3, a2, a1, a0, en, pend;
    logic [3:0]  dig;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(.DIV(DIV)) dut (
        .CLK(clk), .nRST(n_rst), .D(d), .LD(ld), .LZB(lzb), .BLK(blk),
        .A3(a3), .A2(a2), .A1(a1), .A0(a0), .EN(en), .DIG(dig), .PEND(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot timing derived from the number of edges since reset release.
    int          n;
    bit          started = 0;
    logic [15:0] m_disp, m_pval;
    logic        m_pend;
    logic [3:0]  e_dig, e_nib;
    logic        e_en;

    always @(posedge clk) begin
        if (!n_rst) begin
            started = 1;
            n = 0;
            m_disp = 16'h0; m_pval = 16'h0; m_pend = 0;
            e_dig = 4'hF; e_en = 0; e_nib = 4'h0;
        end else begin
            bit tk, boundary;
            int slot;
            logic [15:0] upper;
            tk = (n % DIV) == DIV - 1;
            slot = (n / DIV) % 4;
            boundary = tk && (slot == 3);
            upper = m_disp >> (4 * slot);
            if (blk) begin
                e_dig = 4'hF;
                e_en = 0;
            end else if (tk) begin
                e_dig = ~(4'h1 << slot);
                e_nib = upper[3:0];
                e_en = !(lzb && slot != 0 && upper == 16'h0);
            end
            if (ld) begin
                if (boundary) begin m_disp = d; m_pend = 0; end
                else begin m_pval = d; m_pend = 1; end
            end else if (boundary && m_pend) begin
                m_disp = m_pval; m_pend = 0;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("dig", 32'(dig), 32'(e_dig));
            check("en", 32'(en), 32'(e_en));
            check("nib", 32'({a3, a2, a1, a0}), 32'(e_nib));
            check("pend", 32'(pend), 32'(m_pend));
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    logic       obs_en [4];
    logic [3:0] obs_nib [4];

    // Watch one full frame and record what each digit slot showed.
    task automatic observe_frame();
        for (int i = 0; i < 4; i++) begin obs_en[i] = 1'bx; obs_nib[i] = 4'hx; end
        for (int c = 0; c < 4 * DIV; c++) begin
            step(1);
            for (int i = 0; i < 4; i++)
                if (dig[i] == 1'b0) begin obs_en[i] = en; obs_nib[i] = {a3, a2, a1, a0}; end
        end
    endtask

    task automatic load(input logic [15:0] v);
        ld = 1; d = v; step(1); ld = 0;
    endtask

    initial begin
        n_rst = 0; d = 16'h0; ld = 0; lzb = 0; blk = 0;
        step(3);
        check("rst_dig", 32'(dig), 32'hF);
        check("rst_en", 32'(en), 32'h0);
        check("rst_pend", 32'(pend), 32'h0);

        // First scan after release
        n_rst = 1;
        step(3);
        check("pre_tick_dig", 32'(dig), 32'hF);
        step(1);
        check("first_dig", 32'(dig), 32'hE);
        check("first_en", 32'(en), 32'h1);
        step(4); check("scan_d1", 32'(dig), 32'hD);
        step(4); check("scan_d2", 32'(dig), 32'hB);
        step(4); check("scan_d3", 32'(dig), 32'h7);
        step(4); check("scan_wrap", 32'(dig), 32'hE);

        // Mid-frame load waits for the boundary
        ld = 1; d = 16'h1234; step(1); ld = 0;
        check("ld_pend", 32'(pend), 32'h1);
        step(11);
        check("bnd_pend", 32'(pend), 32'h0);
        check("bnd_dig3_old", 32'({a3, a2, a1, a0}), 32'h0);
        step(4);
        check("new_d0_dig", 32'(dig), 32'hE);
        check("new_d0_nib", 32'({a3, a2, a1, a0}), 32'h4);

        // Load on the boundary tick bypasses pending
        step(11);
        ld = 1; d = 16'h5678; step(1); ld = 0;
        check("byp_pend", 32'(pend), 32'h0);
        check("byp_dig3_old", 32'({a3, a2, a1, a0}), 32'h1);
        step(4);
        check("byp_d0_nib", 32'({a3, a2, a1, a0}), 32'h8);

        // Last load wins
        load(16'h1111); load(16'h2222);
        step(8 * DIV);
        observe_frame();
        for (int i = 0; i < 4; i++) check("last_wins", 32'(obs_nib[i]), 32'h2);

        // Leading-zero blanking
        lzb = 1; load(16'h0040); step(8 * DIV);
        observe_frame();
        check("lzb_en3", 32'(obs_en[3]), 32'h0);
        check("lzb_en2", 32'(obs_en[2]), 32'h0);
        check("lzb_en1", 32'(obs_en[1]), 32'h1);
        check("lzb_en0", 32'(obs_en[0]), 32'h1);
        check("lzb_nib1", 32'(obs_nib[1]), 32'h4);
        load(16'h0000); step(8 * DIV);
        observe_frame();
        for (int i = 0; i < 4; i++) check("lzb_zero", 32'(obs_en[i]), (i == 0) ? 32'h1 : 32'h0);
        lzb = 0; step(4 * DIV);
        observe_frame();
        for (int i = 0; i < 4; i++) check("nolzb_en", 32'(obs_en[i]), 32'h1);

        // Global blank mid-frame
        step(5);
        blk = 1; step(1);
        check("blk_dig", 32'(dig), 32'hF);
        check("blk_en", 32'(en), 32'h0);
        step(9); blk = 0;
        step(4 * DIV);

        // Reset discards a pending value
        load(16'h9999);
        check("pre_rst_pend", 32'(pend), 32'h1);
        n_rst = 0; step(1); n_rst = 1;
        check("rst2_dig", 32'(dig), 32'hF);
        check("rst2_pend", 32'(pend), 32'h0);
        step(8 * DIV);
        observe_frame();
        for (int i = 0; i < 4; i++) check("rst2_nib", 32'(obs_nib[i]), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] v;
            v = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
            d = v;
            ld = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) lzb = ~lzb;
            if ($urandom_range(0, 29) == 0) blk = ~blk;
            n_rst = ($urandom_range(0, 699) != 0);
            step(1);
        end
        n_rst = 1; ld = 0; blk = 0;
        step(4 * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed 4-digit scanner that sits directly upstream of the seven-segment decoder.
- Holds a 4-digit BCD value and steps through the digits at a prescaled rate.
- Drives the decoder's data nibble (A3..A0) and its EN input for each digit, plus active-low digit-select lines for the common-cathode display.
- New values are loaded through a strobe and take effect only at frame boundaries, so a frame never shows a torn value.

Parameters:
DIV, 50000, scan prescale: CLK cycles per digit slot; legal range DIV >= 2; frame length = 4*DIV cycles.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
nRST  input  1  reset, synchronous, active-low.
D  input  16  BCD value; D[3:0] is digit 0 (least significant), D[15:12] is digit 3.
LD  input  1  load strobe; D is captured on any cycle where LD=1.
LZB  input  1  leading-zero blanking enable.
BLK  input  1  global blank.
A3,A2,A1,A0  output  1 each  nibble of the current digit, to the decoder.
EN  output  1  segment enable, to the decoder.
DIG  output  4  digit selects, active-low one-hot; DIG[i]=0 selects digit i.
PEND  output  1  high while a loaded value waits for the frame boundary.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous, active-low on nRST. All outputs are registered.
- Reset values (nRST=0 at an edge):
  - prescaler = 0, index = 0.
  - display register = 0, pending register = 0, PEND = 0.
  - DIG = 4'b1111, EN = 0, A3..A0 = 0.
  - Reset mid-frame aborts the scan and discards any pending value.
- Prescaler: counts 0..DIV-1 and wraps. tick = (count == DIV-1).
- Index: advances 0->1->2->3->0, one step per tick.
  - A frame boundary is a tick that takes the index from 3 to 0.
- Output update: on the edge where tick=1, outputs are loaded for the new index. Between ticks the outputs hold.
  - First output after reset release: digit 0 is shown on the first tick edge, i.e. DIV cycles after release. DIG stays 1111 until then.
  - Per slot: DIG = ~(1<<index); A3..A0 = display[4*index+3 : 4*index].
- Load path:
  - LD=1 writes D into the pending register and sets PEND on the next edge.
  - Repeated LD while PEND=1 overwrites the pending value (last wins).
  - At a frame-boundary edge with PEND=1: display <= pending, PEND <= 0. Digit 0 of the new frame already shows the new value.
  - LD=1 on the same cycle as the frame-boundary tick: D goes straight into display on that edge, bypassing pending, and PEND ends 0.
- Leading-zero blanking (LZB=1): digit i (i = 3..1) is blanked (EN=0) when display nibbles i..3 are all zero. Digit 0 is never blanked, so a value of 0000 shows "0".
  - With LZB=0, EN=1 for every slot.
- Non-BCD nibbles (A..F) pass through unchanged. No saturation or correction.
- BLK=1 forces DIG=4'b1111 and EN=0 on the next edge, regardless of tick.
  - The prescaler, index and load path keep running underneath.
  - On release, outputs resume at the next tick.
- LZB and BLK are sampled every cycle. Changes to LZB appear at the next tick edge.

Decomposition:
- Shared package display_pkg:
  - NDIGITS = 4
  - NIB_W = 4
  - DIG_OFF = 4'b1111
  - typedef digit_idx_t (2-bit)
  - typedef bcd4_t (16-bit)
- One sub-module, scan_prescaler:
  - parameter DIV; ports CLK, nRST, output tick.
  - Reused by later multiplexed-display blocks.
- Blanking logic, index counter and load registers stay in the top module.

Test Plan:
1. Reset/first scan: DIV=4, nRST low 3 cycles then high, LD=0. DIG=1111 and EN=0 for 4 cycles after release, then DIG=1110, A=0000, EN=1; then 1101, 1011, 0111, each held 4 cycles, wrapping to 1110.
2. Frame-boundary load: DIV=4, LD pulse with D=16'h1234 mid-frame (index 1). PEND=1 next cycle; digits 1..3 of the current frame still show 0; at the boundary PEND=0 and slots show 4,3,2,1 for digits 0..3.
3. Last-wins and bypass:
   - LD with 16'h1111, then LD with 16'h2222 before the boundary: display becomes 2222.
   - LD with 16'h5678 on the exact boundary tick cycle: display = 5678 immediately and PEND stays 0.
4. Leading-zero blanking: display 16'h0040, LZB=1. EN=0 for digits 3 and 2, EN=1 for digit 1 (A=0100) and digit 0 (A=0000).
   - Display 16'h0000: only digit 0 has EN=1.
   - LZB=0: all four slots have EN=1.
5. Global blank: BLK=1 for 10 cycles mid-frame. DIG=1111 and EN=0 from the next edge. After release, the next tick shows the index the scan has reached in the meantime (cycle count preserved), not a restarted scan.
6. Reset mid-operation: PEND=1 with index 2, assert nRST for 1 cycle. All outputs return to reset values, PEND=0, and the pending value is never displayed.
